// File: rtl/ram_boot_arbiter_pkg.sv
// Shared definitions for the RAM boot arbiter: loader FSM state codes,
// default frame marker and the length-field decode helper.
package ram_boot_arbiter_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_ADDR_HI = 3'd1;
   localparam state_t ST_ADDR_LO = 3'd2;
   localparam state_t ST_LEN     = 3'd3;
   localparam state_t ST_DATA    = 3'd4;
   localparam state_t ST_CSUM    = 3'd5;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // A length byte of zero encodes a full 256-byte payload.
   function automatic logic [8:0] len_to_count(input logic [7:0] len);
      return (len == 8'h00) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/ram_boot_arbiter_if.sv
// Bus bundle between the core, the byte-stream loader and the RAM port.
// The arbiter takes the slave view; whatever drives the core/loader side takes the master view.
interface ram_boot_arbiter_if;

   logic [15:0] cpu_ram_addr;
   logic [7:0]  cpu_ram_data;
   logic        cpu_ram_we;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_ready;
   logic [15:0] ram_addr;
   logic [7:0]  ram_data;
   logic        ram_we;
   logic        cpu_run;
   logic        ld_busy;
   logic        ld_done;
   logic        ld_err;

   modport slave (
      input  cpu_ram_addr, cpu_ram_data, cpu_ram_we, ld_valid, ld_data,
      output ld_ready, ram_addr, ram_data, ram_we, cpu_run, ld_busy, ld_done, ld_err
   );

   modport master (
      output cpu_ram_addr, cpu_ram_data, cpu_ram_we, ld_valid, ld_data,
      input  ld_ready, ram_addr, ram_data, ram_we, cpu_run, ld_busy, ld_done, ld_err
   );

endinterface

// File: rtl/ram_boot_arbiter_ld_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the TIMEOUT-th consecutive idle cycle. A clear in the same cycle always wins.
module ram_boot_arbiter_ld_timeout #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int W = $clog2(TIMEOUT);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = i_enable && !i_clear && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/ram_boot_arbiter.sv
// Shares the single RAM port between the core and a framed byte-stream loader,
// writing payload bytes straight through and freezing the core while a frame is in flight.
module ram_boot_arbiter
   import ram_boot_arbiter_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         TIMEOUT   = 1024,
   parameter bit         BOOT_HOLD = 1'b1
) (
   input logic              clk,
   input logic              rst,
   ram_boot_arbiter_if.slave bus
);

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_addr;
   logic [8:0]  r_cnt;
   logic [7:0]  r_sum;
   logic        r_booted;
   logic        r_cpu_run;
   logic        r_err;

   logic        w_accept;
   logic        w_busy;
   logic        w_expired;
   logic        w_is_sync;
   logic [7:0]  w_sum_next;
   logic        w_csum_ok;

   // Bytes presented while reset is asserted must never reach the RAM.
   assign w_accept   = bus.ld_valid & ~rst;
   assign w_busy     = (r_state != ST_IDLE);
   assign w_is_sync  = (bus.ld_data == SYNC_BYTE);
   assign w_sum_next = r_sum + bus.ld_data;
   assign w_csum_ok  = (w_sum_next == 8'h00);

   ram_boot_arbiter_ld_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_ld_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_accept | ~w_busy),
      .i_enable  (w_busy),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_expired) begin
         w_state_next = ST_IDLE;
      end else if (w_accept) begin
         case (r_state)
            ST_IDLE:    if (w_is_sync) w_state_next = ST_ADDR_HI;
            ST_ADDR_HI: w_state_next = ST_ADDR_LO;
            ST_ADDR_LO: w_state_next = ST_LEN;
            ST_LEN:     w_state_next = ST_DATA;
            ST_DATA:    if (r_cnt == 9'd1) w_state_next = ST_CSUM;
            ST_CSUM:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
         endcase
      end
   end

   // Port mux: the core passes straight through whenever no frame is active.
   always_comb begin
      bus.ram_addr = bus.cpu_ram_addr;
      bus.ram_data = bus.cpu_ram_data;
      bus.ram_we   = bus.cpu_ram_we;
      bus.ld_done  = 1'b0;
      if (w_busy) begin
         bus.ram_addr = r_addr;
         bus.ram_data = bus.ld_data;
         bus.ram_we   = (r_state == ST_DATA) && w_accept;
      end
      if ((r_state == ST_CSUM) && w_accept && w_csum_ok) begin
         bus.ld_done = 1'b1;
      end
   end

   assign bus.ld_ready = 1'b1;
   assign bus.ld_busy  = w_busy;
   assign bus.cpu_run  = r_cpu_run;
   assign bus.ld_err   = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr    <= 16'h0000;
         r_cnt     <= 9'd0;
         r_sum     <= 8'h00;
         r_booted  <= 1'b0;
         r_cpu_run <= ~BOOT_HOLD;
         r_err     <= 1'b0;
      end else if (w_expired) begin
         r_err     <= 1'b1;
         r_cpu_run <= r_booted;
      end else if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               if (w_is_sync) begin
                  r_sum     <= 8'h00;
                  r_err     <= 1'b0;
                  r_cpu_run <= 1'b0;
               end
            end
            ST_ADDR_HI: begin
               r_addr[15:8] <= bus.ld_data;
               r_sum        <= w_sum_next;
            end
            ST_ADDR_LO: begin
               r_addr[7:0] <= bus.ld_data;
               r_sum       <= w_sum_next;
            end
            ST_LEN: begin
               r_cnt <= len_to_count(bus.ld_data);
               r_sum <= w_sum_next;
            end
            ST_DATA: begin
               r_addr <= r_addr + 16'd1;
               r_cnt  <= r_cnt - 9'd1;
               r_sum  <= w_sum_next;
            end
            ST_CSUM: begin
               // Bytes already written stay in RAM whether or not the frame checks out.
               if (w_csum_ok) begin
                  r_booted  <= 1'b1;
                  r_cpu_run <= 1'b1;
               end else begin
                  r_err     <= 1'b1;
                  r_cpu_run <= r_booted;
               end
            end
            default: begin
               r_sum <= r_sum;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_boot_arbiter.sv
// Self-checking bench for ram_boot_arbiter: framed loads scored against a write queue,
// plus a vector table for core pass-through and hand-written timeout/reset sequences.
module tb_ram_boot_arbiter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ram_boot_arbiter_if bus ();

   ram_boot_arbiter #(
      .SYNC_BYTE (8'hA5),
      .TIMEOUT   (1024),
      .BOOT_HOLD (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic [15:0] cpu_addr;
      logic [7:0]  cpu_data;
      logic        cpu_we;
      logic        ld_v;
      logic [7:0]  ld_d;
      logic [15:0] exp_addr;
      logic [7:0]  exp_data;
      logic        exp_we;
   } vec_t;

   int   total = 0;
   int   bad = 0;
   wr_t  exp_q[$];
   wr_t  mon_e;
   int   writes_seen = 0;
   int   done_seen = 0;
   logic run_at_done = 1'b1;
   logic run_mid = 1'b1;
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard side: every loader write seen on the RAM port must match the queue head.
   always @(negedge clk) begin
      if (bus.ld_done === 1'b1) begin
         done_seen++;
         run_at_done = bus.cpu_run;
      end
      if (bus.ram_we === 1'b1 && bus.ld_busy === 1'b1) begin
         writes_seen++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                     bus.ram_addr, bus.ram_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(bus.ram_addr), 32'(mon_e.addr));
            check("wr_data", 32'(bus.ram_data), 32'(mon_e.data));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stall(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.ld_valid = 1'b1;
      bus.ld_data  = b;
      tick();
      bus.ld_valid = 1'b0;
   endtask

   task automatic send_body(input logic [15:0] base, input int n, input logic [7:0] seed,
                            input logic [7:0] cadj);
      logic [7:0] sum;
      logic [7:0] len;
      logic [7:0] p;
      logic [7:0] c;
      len = 8'(n);
      sum = base[15:8] + base[7:0] + len;
      send_byte(base[15:8]);
      send_byte(base[7:0]);
      send_byte(len);
      for (int i = 0; i < n; i++) begin
         p = seed + 8'(i * 17);
         sum = sum + p;
         exp_q.push_back({base + 16'(i), p});
         send_byte(p);
      end
      c = 8'h00 - sum + cadj;
      send_byte(c);
   endtask

   task automatic send_frame(input logic [15:0] base, input int n, input logic [7:0] seed,
                             input logic [7:0] cadj);
      send_byte(8'hA5);
      run_mid = bus.cpu_run;
      send_body(base, n, seed, cadj);
   endtask

   initial begin
      int d0;
      int w0;

      vecs[0] = '{16'h1234, 8'h56, 1'b1, 1'b0, 8'h00, 16'h1234, 8'h56, 1'b1};
      vecs[1] = '{16'hFFFF, 8'hFF, 1'b1, 1'b1, 8'h3C, 16'hFFFF, 8'hFF, 1'b1};
      vecs[2] = '{16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 1'b0};
      vecs[3] = '{16'hA5A5, 8'hA5, 1'b1, 1'b0, 8'h00, 16'hA5A5, 8'hA5, 1'b1};
      vecs[4] = '{16'h8001, 8'h7E, 1'b0, 1'b1, 8'h00, 16'h8001, 8'h7E, 1'b0};

      bus.cpu_ram_addr = 16'h0000;
      bus.cpu_ram_data = 8'h00;
      bus.cpu_ram_we   = 1'b0;
      bus.ld_valid     = 1'b0;
      bus.ld_data      = 8'h00;
      rst = 1'b1;
      stall(3);
      check("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
      check("rst_busy",    32'(bus.ld_busy), 32'd0);
      check("rst_err",     32'(bus.ld_err),  32'd0);
      check("rst_done",    32'(bus.ld_done), 32'd0);
      check("rst_ready",   32'(bus.ld_ready), 32'd1);
      rst = 1'b0;
      tick();

      send_byte(8'h11);
      send_byte(8'h5A);
      check("idle_drop_busy", 32'(bus.ld_busy), 32'd0);
      check("idle_drop_writes", 32'(writes_seen), 32'd0);

      // First good frame releases the held core.
      d0 = done_seen;
      send_frame(16'h0100, 2, 8'h11, 8'h00);
      check("t1_run_frozen", 32'(run_mid), 32'd0);
      check("t1_run_at_done", 32'(run_at_done), 32'd0);
      check("t1_done", 32'(done_seen - d0), 32'd1);
      check("t1_cpu_run", 32'(bus.cpu_run), 32'd1);
      check("t1_err", 32'(bus.ld_err), 32'd0);
      tick();
      check("t1_done_width", 32'(done_seen - d0), 32'd1);
      check("t1_busy", 32'(bus.ld_busy), 32'd0);

      d0 = done_seen;
      send_frame(16'hFFFF, 2, 8'h33, 8'h00);
      check("t2_run_frozen", 32'(run_mid), 32'd0);
      check("t2_done", 32'(done_seen - d0), 32'd1);
      check("t2_err", 32'(bus.ld_err), 32'd0);
      check("t2_queue", 32'(exp_q.size()), 32'd0);

      d0 = done_seen;
      w0 = writes_seen;
      send_frame(16'h2000, 3, 8'h01, 8'h01);
      check("t3_done", 32'(done_seen - d0), 32'd0);
      check("t3_err", 32'(bus.ld_err), 32'd1);
      check("t3_cpu_run", 32'(bus.cpu_run), 32'd1);
      check("t3_writes", 32'(writes_seen - w0), 32'd3);
      send_byte(8'hA5);
      check("t3_sync_clr_err", 32'(bus.ld_err), 32'd0);
      check("t3_sync_busy", 32'(bus.ld_busy), 32'd1);
      check("t3_sync_run", 32'(bus.cpu_run), 32'd0);
      send_body(16'h2100, 1, 8'h77, 8'h00);
      check("t3b_done", 32'(done_seen - d0), 32'd1);
      check("t3b_run", 32'(bus.cpu_run), 32'd1);

      d0 = done_seen;
      w0 = writes_seen;
      send_frame(16'h3000, 256, 8'h05, 8'h00);
      check("t4_writes", 32'(writes_seen - w0), 32'd256);
      check("t4_done", 32'(done_seen - d0), 32'd1);
      check("t4_busy", 32'(bus.ld_busy), 32'd0);
      check("t4_queue", 32'(exp_q.size()), 32'd0);

      // Stall right after the address bytes until the watchdog fires.
      d0 = done_seen;
      w0 = writes_seen;
      send_byte(8'hA5);
      send_byte(8'h40);
      send_byte(8'h00);
      stall(1023);
      check("t5_busy_before", 32'(bus.ld_busy), 32'd1);
      stall(1);
      check("t5_busy_after", 32'(bus.ld_busy), 32'd0);
      check("t5_err", 32'(bus.ld_err), 32'd1);
      check("t5_cpu_run", 32'(bus.cpu_run), 32'd1);
      check("t5_writes", 32'(writes_seen - w0), 32'd0);
      check("t5_done", 32'(done_seen - d0), 32'd0);

      // A byte arriving on the expiry cycle keeps the frame alive.
      send_byte(8'hA5);
      send_byte(8'h41);
      send_byte(8'h00);
      stall(1023);
      check("t5b_busy_edge", 32'(bus.ld_busy), 32'd1);
      send_byte(8'h01);
      check("t5b_byte_wins", 32'(bus.ld_busy), 32'd1);
      check("t5b_err_clear", 32'(bus.ld_err), 32'd0);
      stall(1023);
      check("t5b_busy_data", 32'(bus.ld_busy), 32'd1);
      stall(1);
      check("t5b_timeout", 32'(bus.ld_busy), 32'd0);
      check("t5b_err", 32'(bus.ld_err), 32'd1);
      check("t5b_writes", 32'(writes_seen - w0), 32'd0);

      for (int i = 0; i < 5; i++) begin
         bus.cpu_ram_addr = vecs[i].cpu_addr;
         bus.cpu_ram_data = vecs[i].cpu_data;
         bus.cpu_ram_we   = vecs[i].cpu_we;
         bus.ld_valid     = vecs[i].ld_v;
         bus.ld_data      = vecs[i].ld_d;
         @(negedge clk);
         check("vec_addr", 32'(bus.ram_addr), 32'(vecs[i].exp_addr));
         check("vec_data", 32'(bus.ram_data), 32'(vecs[i].exp_data));
         check("vec_we",   32'(bus.ram_we),   32'(vecs[i].exp_we));
         check("vec_busy", 32'(bus.ld_busy),  32'd0);
         check("vec_run",  32'(bus.cpu_run),  32'd1);
         tick();
      end
      bus.cpu_ram_we = 1'b0;
      bus.ld_valid   = 1'b0;

      // Reset in the middle of a payload.
      send_byte(8'hA5);
      send_byte(8'h50);
      send_byte(8'h00);
      send_byte(8'h04);
      exp_q.push_back({16'h5000, 8'hC1});
      send_byte(8'hC1);
      exp_q.push_back({16'h5001, 8'hC2});
      send_byte(8'hC2);
      rst = 1'b1;
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h99;
      tick();
      bus.ld_data  = 8'hA5;
      tick();
      check("t6_rst_busy", 32'(bus.ld_busy), 32'd0);
      check("t6_rst_run", 32'(bus.cpu_run), 32'd0);
      rst = 1'b0;
      bus.ld_valid = 1'b0;
      tick();
      check("t6_busy", 32'(bus.ld_busy), 32'd0);
      check("t6_run", 32'(bus.cpu_run), 32'd0);
      check("t6_err", 32'(bus.ld_err), 32'd0);
      bus.cpu_ram_addr = 16'hBEEF;
      bus.cpu_ram_data = 8'h42;
      bus.cpu_ram_we   = 1'b1;
      @(negedge clk);
      check("t6_pass_addr", 32'(bus.ram_addr), 32'h0000BEEF);
      check("t6_pass_data", 32'(bus.ram_data), 32'h42);
      check("t6_pass_we", 32'(bus.ram_we), 32'd1);
      tick();
      bus.cpu_ram_we = 1'b0;
      tick();
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
